// File: rtl/cpu_types_pkg.sv
// Shared CPU cache types: data word, MSI coherence state and snoop FSM state encodings.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef logic [1:0] msi_t;
  localparam msi_t MSI_I = 2'b00;
  localparam msi_t MSI_S = 2'b01;
  localparam msi_t MSI_M = 2'b10;

  typedef logic [2:0] snoop_state_t;
  localparam snoop_state_t ST_IDLE    = 3'd0;
  localparam snoop_state_t ST_LOOKUP  = 3'd1;
  localparam snoop_state_t ST_RESP    = 3'd2;
  localparam snoop_state_t ST_WB0     = 3'd3;
  localparam snoop_state_t ST_WB1     = 3'd4;
  localparam snoop_state_t ST_UPDATE  = 3'd5;
  localparam snoop_state_t ST_RELEASE = 3'd6;

  // The unused encoding 2'b11 is folded onto Invalid.
  function automatic msi_t msi_norm(input msi_t m);
    if (m == 2'b11) begin
      return MSI_I;
    end else begin
      return m;
    end
  endfunction

endpackage

// File: rtl/snoop_stats.sv
// Snoop statistics counters (snoops, hits, completed writebacks); built only with SNOOP_STATS_EN.
`ifdef SNOOP_STATS_EN
module snoop_stats
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  resp_i,
  input  logic  hit_i,
  input  logic  wb_done_i,
  output word_t snoop_cnt_o,
  output word_t hit_cnt_o,
  output word_t wb_cnt_o
);

  word_t snoop_cnt_q, hit_cnt_q, wb_cnt_q;

  // Free-running counters, wrapping naturally at 2^32.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      snoop_cnt_q <= 32'd0;
      hit_cnt_q   <= 32'd0;
      wb_cnt_q    <= 32'd0;
    end else begin
      if (resp_i)           snoop_cnt_q <= snoop_cnt_q + 32'd1;
      if (resp_i && hit_i)  hit_cnt_q   <= hit_cnt_q + 32'd1;
      if (wb_done_i)        wb_cnt_q    <= wb_cnt_q + 32'd1;
    end
  end

  assign snoop_cnt_o = snoop_cnt_q;
  assign hit_cnt_o   = hit_cnt_q;
  assign wb_cnt_o    = wb_cnt_q;

endmodule
`endif

// File: rtl/snoop_responder.sv
// Cache snoop responder: lookup, respond, write back dirty block, update MSI state.
// Optional statistics counters are enabled with the SNOOP_STATS_EN macro.
module snoop_responder
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ccwait,
  input  logic        ccinv,
  input  logic [31:0] ccsnoopaddr,
  input  logic        dwait,
  input  logic        lk_hit,
  input  logic        lk_way,
  input  logic [1:0]  lk_msi,
  input  logic [31:0] lk_word0,
  input  logic [31:0] lk_word1,
  output logic [25:0] lk_tag,
  output logic [2:0]  lk_idx,
  output logic        cctrans,
  output logic        ccwrite,
  output logic        snp_active,
  output logic [31:0] snp_daddr,
  output logic [31:0] snp_dstore,
  output logic        upd_en,
  output logic        upd_way,
  output logic [2:0]  upd_idx,
  output logic [1:0]  upd_msi
`ifdef SNOOP_STATS_EN
  ,
  output logic [31:0] snoop_cnt,
  output logic [31:0] hit_cnt,
  output logic [31:0] wb_cnt
`endif
);

  snoop_state_t state_q, state_d;
  logic [28:0]  addr_q, addr_d;   // {tag, idx}; the block offset is implied by WB0/WB1
  logic         inv_q, inv_d;
  logic         hit_q, hit_d;
  logic         way_q, way_d;
  msi_t         msi_q, msi_d;
  word_t        w0_q, w0_d;
  word_t        w1_q, w1_d;
  logic         unused_blkoff;

  assign unused_blkoff = ^ccsnoopaddr[2:0];

  // State and captured-snoop registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= ST_IDLE;
      addr_q  <= 29'd0;
      inv_q   <= 1'b0;
      hit_q   <= 1'b0;
      way_q   <= 1'b0;
      msi_q   <= MSI_I;
      w0_q    <= 32'd0;
      w1_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      inv_q   <= inv_d;
      hit_q   <= hit_d;
      way_q   <= way_d;
      msi_q   <= msi_d;
      w0_q    <= w0_d;
      w1_q    <= w1_d;
    end
  end

  // Next-state and capture logic.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    inv_d   = inv_q;
    hit_d   = hit_q;
    way_d   = way_q;
    msi_d   = msi_q;
    w0_d    = w0_q;
    w1_d    = w1_q;
    case (state_q)
      ST_IDLE: begin
        if (ccwait) begin
          addr_d  = ccsnoopaddr[31:3];
          inv_d   = ccinv;
          state_d = ST_LOOKUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOOKUP: begin
        hit_d   = lk_hit;
        way_d   = lk_way;
        msi_d   = msi_norm(lk_msi);
        w0_d    = lk_word0;
        w1_d    = lk_word1;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (hit_q && (msi_q == MSI_M)) begin
          state_d = ST_WB0;
        end else if (hit_q && (msi_q == MSI_S) && inv_q) begin
          state_d = ST_UPDATE;
        end else begin
          state_d = ST_RELEASE;
        end
      end
      // Losing the bus mid-writeback abandons the snoop without touching state.
      ST_WB0: begin
        if (!ccwait) begin
          state_d = ST_IDLE;
        end else if (!dwait) begin
          state_d = ST_WB1;
        end else begin
          state_d = ST_WB0;
        end
      end
      ST_WB1: begin
        if (!ccwait) begin
          state_d = ST_IDLE;
        end else if (!dwait) begin
          state_d = ST_UPDATE;
        end else begin
          state_d = ST_WB1;
        end
      end
      ST_UPDATE: state_d = ST_RELEASE;
      ST_RELEASE: begin
        if (!ccwait) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RELEASE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore output decode from the state and captured registers only.
  always_comb begin
    lk_tag     = 26'd0;
    lk_idx     = 3'd0;
    cctrans    = 1'b0;
    ccwrite    = 1'b0;
    snp_daddr  = 32'd0;
    snp_dstore = 32'd0;
    upd_en     = 1'b0;
    upd_way    = 1'b0;
    upd_idx    = 3'd0;
    upd_msi    = MSI_I;
    snp_active = (state_q != ST_IDLE);
    case (state_q)
      ST_LOOKUP: begin
        lk_tag = addr_q[28:3];
        lk_idx = addr_q[2:0];
      end
      ST_RESP: begin
        cctrans = 1'b1;
        ccwrite = hit_q && (msi_q == MSI_M);
      end
      ST_WB0: begin
        snp_daddr  = {addr_q, 3'b000};
        snp_dstore = w0_q;
      end
      ST_WB1: begin
        snp_daddr  = {addr_q, 3'b100};
        snp_dstore = w1_q;
      end
      ST_UPDATE: begin
        upd_en  = 1'b1;
        upd_way = way_q;
        upd_idx = addr_q[2:0];
        if (inv_q) begin
          upd_msi = MSI_I;
        end else begin
          upd_msi = MSI_S;
        end
      end
      default: begin
        lk_tag = 26'd0;
      end
    endcase
  end

`ifdef SNOOP_STATS_EN
  snoop_stats u_stats (
    .CLK         (CLK),
    .nRST        (nRST),
    .resp_i      (state_q == ST_RESP),
    .hit_i       (hit_q),
    .wb_done_i   ((state_q == ST_WB1) && ccwait && !dwait),
    .snoop_cnt_o (snoop_cnt),
    .hit_cnt_o   (hit_cnt),
    .wb_cnt_o    (wb_cnt)
  );
`endif

endmodule

// File: tb/tb_snoop_responder.sv
// Scoreboard bench for snoop_responder; define SNOOP_STATS_EN to also check the counters.
module tb_snoop_responder;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        ccwait = 1'b0, ccinv = 1'b0, dwait = 1'b1;
  logic [31:0] ccsnoopaddr = 32'd0;
  logic        lk_hit = 1'b0, lk_way = 1'b0;
  logic [1:0]  lk_msi = 2'b00;
  logic [31:0] lk_word0 = 32'd0, lk_word1 = 32'd0;
  logic [25:0] lk_tag;
  logic [2:0]  lk_idx;
  logic        cctrans, ccwrite, snp_active, upd_en, upd_way;
  logic [31:0] snp_daddr, snp_dstore;
  logic [2:0]  upd_idx;
  logic [1:0]  upd_msi;
`ifdef SNOOP_STATS_EN
  logic [31:0] snoop_cnt, hit_cnt, wb_cnt;
`endif

  int total = 0;
  int bad = 0;

  logic        resp_q[$];   // expected ccwrite per cctrans pulse
  logic [63:0] wb_q[$];     // expected {daddr, dstore} per accepted word
  logic [5:0]  upd_q[$];    // expected {way, idx, msi} per upd_en pulse

  logic [31:0] prev_a, prev_d;
  logic        prev_hold = 1'b0;

  snoop_responder dut (
    .CLK(CLK), .nRST(nRST), .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .dwait(dwait), .lk_hit(lk_hit), .lk_way(lk_way), .lk_msi(lk_msi),
    .lk_word0(lk_word0), .lk_word1(lk_word1), .lk_tag(lk_tag), .lk_idx(lk_idx),
    .cctrans(cctrans), .ccwrite(ccwrite), .snp_active(snp_active),
    .snp_daddr(snp_daddr), .snp_dstore(snp_dstore), .upd_en(upd_en),
    .upd_way(upd_way), .upd_idx(upd_idx), .upd_msi(upd_msi)
`ifdef SNOOP_STATS_EN
    , .snoop_cnt(snoop_cnt), .hit_cnt(hit_cnt), .wb_cnt(wb_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops scoreboard entries as the DUT produces responses.
  always @(negedge CLK) begin
    if (!nRST) begin
      prev_hold = 1'b0;
    end else begin
      if (cctrans) begin
        check_val("resp_pending", 64'(resp_q.size() != 0), 64'd1);
        if (resp_q.size() != 0) check_val("ccwrite", 64'(ccwrite), 64'(resp_q.pop_front()));
      end
      if (prev_hold && snp_daddr != 32'd0) begin
        check_val("hold_addr", 64'(snp_daddr), 64'(prev_a));
        check_val("hold_data", 64'(snp_dstore), 64'(prev_d));
      end
      if (snp_daddr != 32'd0 && !dwait && ccwait) begin
        check_val("wb_pending", 64'(wb_q.size() != 0), 64'd1);
        if (wb_q.size() != 0) check_val("wb_word", {snp_daddr, snp_dstore}, wb_q.pop_front());
      end
      if (upd_en) begin
        check_val("upd_pending", 64'(upd_q.size() != 0), 64'd1);
        if (upd_q.size() != 0) check_val("upd", 64'({upd_way, upd_idx, upd_msi}), 64'(upd_q.pop_front()));
      end
      prev_hold = (snp_daddr != 32'd0) && dwait;
      prev_a    = snp_daddr;
      prev_d    = snp_dstore;
    end
  end

  task automatic start_snoop(input logic [31:0] a, input logic inv, input logic hit,
                             input logic way, input logic [1:0] msi,
                             input logic [31:0] w0, input logic [31:0] w1, input logic dw);
    logic is_m, is_s;
    is_m = hit && (msi == 2'b10);
    is_s = hit && (msi == 2'b01);
    resp_q.push_back(is_m);
    if (is_m) begin
      wb_q.push_back({a[31:3], 3'b000, w0});
      wb_q.push_back({a[31:3], 3'b100, w1});
      upd_q.push_back({way, a[5:3], (inv ? 2'b00 : 2'b01)});
    end else if (is_s && inv) begin
      upd_q.push_back({way, a[5:3], 2'b00});
    end
    @(posedge CLK); #1;
    ccsnoopaddr = a; ccinv = inv; lk_hit = hit; lk_way = way; lk_msi = msi;
    lk_word0 = w0; lk_word1 = w1; dwait = dw; ccwait = 1'b1;
    @(negedge CLK);
    check_val("c0_cctrans", 64'(cctrans), 64'd0);
    check_val("c0_active", 64'(snp_active), 64'd0);
    @(negedge CLK);
    check_val("c1_cctrans", 64'(cctrans), 64'd0);
    check_val("c1_active", 64'(snp_active), 64'd1);
    check_val("c1_lk_key", 64'({lk_tag, lk_idx}), 64'({a[31:6], a[5:3]}));
    @(negedge CLK);
    check_val("c2_cctrans", 64'(cctrans), 64'd1);
  endtask

  // Accept each writeback word after dly stalled cycles.
  task automatic run_wb(input int dly);
    for (int w = 0; w < 2; w++) begin
      @(posedge CLK); #1 dwait = 1'b1;
      for (int k = 0; k < dly; k++) begin
        @(posedge CLK); #1;
      end
      dwait = 1'b0;
    end
    @(posedge CLK); #1 dwait = 1'b1;
  endtask

  task automatic end_snoop(input string tag);
    int n;
    repeat (2) @(posedge CLK);
    #1 check_val({tag, "_held"}, 64'(snp_active), 64'd1);
    ccwait = 1'b0;
    dwait  = 1'b1;
    n = 0;
    @(negedge CLK);
    while (snp_active && n < 10) begin
      @(negedge CLK);
      n++;
    end
    check_val({tag, "_idle"}, 64'(snp_active), 64'd0);
    repeat (2) @(negedge CLK);
    check_val({tag, "_respq"}, 64'(resp_q.size()), 64'd0);
    check_val({tag, "_wbq"}, 64'(wb_q.size()), 64'd0);
    check_val({tag, "_updq"}, 64'(upd_q.size()), 64'd0);
  endtask

  initial begin
    #2;
    check_val("rst_data", {snp_daddr, snp_dstore}, 64'd0);
    check_val("rst_ctrl", 64'({cctrans, ccwrite, snp_active, upd_en, upd_way, upd_idx, upd_msi, lk_tag, lk_idx}), 64'd0);
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;

    // hit with reserved MSI code, dwait low throughout: behaves as a miss
    start_snoop(32'h0000_0580, 1'b1, 1'b1, 1'b1, 2'b11, 32'h1111_1111, 32'h2222_2222, 1'b0);
    end_snoop("msi11");
    // S without invalidation: no update
    start_snoop(32'h0000_0218, 1'b0, 1'b1, 1'b0, 2'b01, 32'h3333_3333, 32'h4444_4444, 1'b1);
    end_snoop("s_noinv");

    // bus released during WB0: abort with no update
    start_snoop(32'h0000_2010, 1'b0, 1'b1, 1'b1, 2'b10, 32'h5555_5555, 32'h6666_6666, 1'b1);
    @(posedge CLK); #1;
    wb_q.delete(); upd_q.delete();
    ccwait = 1'b0;
    @(negedge CLK);
    check_val("abort_wb0_addr", 64'(snp_daddr), 64'h2010);
    @(negedge CLK);
    check_val("abort_idle", 64'(snp_active), 64'd0);
    repeat (3) @(negedge CLK);
    check_val("abort_updq", 64'(upd_q.size()), 64'd0);

    // reset in the middle of WB1
    start_snoop(32'h0000_3018, 1'b1, 1'b1, 1'b0, 2'b10, 32'h7777_7777, 32'h8888_8888, 1'b1);
    @(posedge CLK); #1 dwait = 1'b0;
    @(posedge CLK); #1 dwait = 1'b1;
    @(negedge CLK);
    check_val("rst_pre_wb1", 64'(snp_daddr), 64'h301C);
    wb_q.delete(); upd_q.delete();
    nRST = 1'b0;
    #1;
    check_val("rst_wb1_data", {snp_daddr, snp_dstore}, 64'd0);
    check_val("rst_wb1_ctrl", 64'({cctrans, ccwrite, snp_active, upd_en, upd_way, upd_idx, upd_msi, lk_tag, lk_idx}), 64'd0);
    @(posedge CLK); #1;
    nRST = 1'b1; ccwait = 1'b0; dwait = 1'b1;
    @(negedge CLK);
    check_val("rst_after_idle", 64'(snp_active), 64'd0);

    // miss, S with invalidate, M without invalidate
    start_snoop(32'h0000_0040, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    end_snoop("miss");
    start_snoop(32'h0000_0628, 1'b1, 1'b1, 1'b1, 2'b01, 32'h9999_9999, 32'hAAAA_AAAA, 1'b1);
    end_snoop("s_inv");
    start_snoop(32'h0000_1008, 1'b0, 1'b1, 1'b0, 2'b10, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1);
    run_wb(0);
    end_snoop("m_noinv");
`ifdef SNOOP_STATS_EN
    check_val("snoop_cnt", 64'(snoop_cnt), 64'd3);
    check_val("hit_cnt", 64'(hit_cnt), 64'd2);
    check_val("wb_cnt", 64'(wb_cnt), 64'd1);
`endif

    // M with invalidate, three stalled cycles per word
    start_snoop(32'h0000_5A30, 1'b1, 1'b1, 1'b1, 2'b10, 32'h0123_4567, 32'h89AB_CDEF, 1'b1);
    run_wb(3);
    end_snoop("m_inv");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
